// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// Handshake: a requester raises x_req with a stable payload and holds both until x_gnt;
// x_gnt is a one-cycle pulse; the result comes back later as a one-cycle x_rvalid pulse.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W/8-1:0]   d_wbe;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wbe;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wbe, d_wdata, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wbe, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wbe, d_wdata, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wbe, mem_wdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Counts contested data grants; raises force_fetch once STARVE_MAX of them ran back to back.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_gnt_contested,
  input  logic fetch_gnt,
  output logic force_fetch
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (fetch_gnt) begin
      cnt <= '0;
    end else if (data_gnt_contested) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_fetch = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-outstanding memory arbiter, data-priority.
// Define MEM_ARB_FAIRNESS_EN to let fetch win after STARVE_MAX contested data grants.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic          stall,
  output logic          err,
  output state_t        dbg_state
);

  state_t            state, state_nxt;
  req_id_t           winner;
  logic              win_valid;
  logic              force_fetch;
  logic              i_gnt_c, d_gnt_c;
  logic              i_rvalid_c, d_rvalid_c;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

`ifdef MEM_ARB_FAIRNESS_EN
  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_cnt (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_gnt_contested (d_gnt_c & bus.i_req),
    .fetch_gnt          (i_gnt_c),
    .force_fetch        (force_fetch)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign force_fetch       = 1'b0;
`endif

  // Issue is gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    win_valid  = rst_n && (state == IDLE) && (bus.i_req || bus.d_req);
    winner     = (bus.d_req && !(bus.i_req && force_fetch)) ? REQ_DATA : REQ_FETCH;
    i_gnt_c    = win_valid && (winner == REQ_FETCH);
    d_gnt_c    = win_valid && (winner == REQ_DATA);
    i_rvalid_c = (state == I_WAIT) && bus.mem_rvalid;
    d_rvalid_c = (state == D_WAIT) && bus.mem_rvalid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_gnt_c)      state_nxt = I_WAIT;
        else if (d_gnt_c) state_nxt = D_WAIT;
      end
      I_WAIT:  if (bus.mem_rvalid) state_nxt = IDLE;
      D_WAIT:  if (bus.mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err       <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && bus.mem_rvalid) err <= 1'b1;
      if (i_rvalid_c) i_rdata_q <= bus.mem_rdata;
      if (d_rvalid_c) d_rdata_q <= bus.mem_rdata;
    end
  end

  // Fetches are always reads; byte enables only travel with data writes.
  assign bus.mem_req   = win_valid;
  assign bus.mem_we    = d_gnt_c && bus.d_we;
  assign bus.mem_wbe   = (d_gnt_c && bus.d_we) ? bus.d_wbe : '0;
  assign bus.mem_wdata = d_gnt_c ? bus.d_wdata : '0;
  assign bus.mem_addr  = d_gnt_c ? bus.d_addr : (i_gnt_c ? bus.i_addr : '0);

  assign bus.i_gnt    = i_gnt_c;
  assign bus.d_gnt    = d_gnt_c;
  assign bus.i_rvalid = i_rvalid_c;
  assign bus.d_rvalid = d_rvalid_c;
  assign bus.i_rdata  = i_rvalid_c ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata  = d_rvalid_c ? bus.mem_rdata : d_rdata_q;

  assign stall     = (bus.i_req && !i_gnt_c) || (bus.d_req && !d_gnt_c) || (state != IDLE);
  assign dbg_state = state;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (byte-enable width DATA_W/8).
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning consecutive contested data grants before a forced fetch grant.
REQ-004 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-005 SHALL have fetch ports i_req (in, 1), i_addr (in, ADDR_W), i_gnt (out, 1), i_rvalid (out, 1) and i_rdata (out, DATA_W).
REQ-006 SHALL have data ports d_req (in, 1), d_we (in, 1), d_addr (in, ADDR_W), d_wbe (in, DATA_W/8), d_wdata (in, DATA_W), d_gnt (out, 1), d_rvalid (out, 1) and d_rdata (out, DATA_W).
REQ-007 SHALL have memory ports mem_req, mem_we, mem_addr, mem_wbe and mem_wdata as outputs, and mem_rvalid (in, 1, read data or write ack) and mem_rdata (in, DATA_W).
REQ-008 SHALL have outputs stall (out, 1, pipeline hold) and err (out, 1, sticky spurious-response flag).

Function
REQ-009 SHALL implement an FSM with states IDLE, I_WAIT and D_WAIT, and SHALL allow at most one outstanding memory transaction.
REQ-010 In IDLE with any request, SHALL assert mem_req combinationally in the same cycle, driving the winner's address, we, wbe and wdata, and SHALL pulse the winner's gnt for exactly that cycle.
REQ-011 A fetch issue SHALL set mem_we=0 and mem_wbe=0; a data read SHALL set mem_wbe=0.
REQ-012 Arbitration SHALL give data priority over fetch when both requests are asserted, except as modified by REQ-024.
REQ-013 A grant SHALL move the FSM to I_WAIT or D_WAIT at the next edge; mem_req SHALL be 0 in both WAIT states.
REQ-014 In x_WAIT, on mem_rvalid=1 SHALL drive x_rdata=mem_rdata and pulse x_rvalid for one cycle (also for write acks), then return to IDLE.
REQ-015 No issue SHALL occur in the response cycle; the next grant is earliest one cycle after x_rvalid.
REQ-016 Requesters hold req and payload stable until gnt; req dropped before gnt SHALL be treated as withdrawn with no side effects.
REQ-017 stall SHALL equal (i_req & ~i_gnt) | (d_req & ~d_gnt) | (state != IDLE).
REQ-018 mem_rvalid in IDLE SHALL be ignored for routing and SHALL set err, which holds until reset.
REQ-019 i_rdata and d_rdata SHALL hold their last delivered value when the corresponding rvalid is 0.

Reset
REQ-020 rst_n low SHALL asynchronously force state IDLE, all gnt, rvalid, mem_req, mem_we, mem_wbe and err to 0, rdata registers to 0, and the starvation counter to 0.
REQ-021 Reset while in a WAIT state SHALL abandon the transaction; a late mem_rvalid after release SHALL follow REQ-018.
REQ-022 The outputs mem_addr and mem_wdata SHALL be 0 while no request is asserted.

Configuration
REQ-023 The block SHALL use macro MEM_ARB_FAIRNESS_EN to select its arbitration mode.
REQ-024 With MEM_ARB_FAIRNESS_EN defined, SHALL count data grants made while i_req=1; when the count equals STARVE_MAX, the next contested grant SHALL go to fetch and the counter SHALL clear; any fetch grant SHALL also clear it.
REQ-025 Without MEM_ARB_FAIRNESS_EN, the counter SHALL be absent and data SHALL have strict priority.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE/I_WAIT/D_WAIT), the requester-ID type and the default widths.
REQ-027 The starvation counter SHALL be one sub-module, arb_starve_cnt, instantiated only under MEM_ARB_FAIRNESS_EN; all other logic SHALL be flat.

Verification
REQ-028 The bench SHALL check: i_req=1, i_addr=0x100, d_req=0 -> same-cycle i_gnt=1, mem_addr=0x100, mem_we=0; mem_rvalid with rdata 0xDEADBEEF two cycles later -> i_rvalid=1, i_rdata=0xDEADBEEF, state IDLE.
REQ-029 The bench SHALL check: i_req=1 and d_req=1, d_we=1, d_addr=0x200, d_wbe=0x3, d_wdata=0x1234 -> d_gnt=1, mem_wbe=0x3, i_gnt=0, stall=1; after the ack, the fetch is granted one cycle after d_rvalid.
REQ-030 The bench SHALL check, with fairness on and STARVE_MAX=4: contested requests for 5 grants -> order D,D,D,D,I; with fairness off -> D×5.
REQ-031 The bench SHALL check: mem_rvalid=1 in IDLE -> err=1 and persists, no rvalid pulse; rst_n low -> err=0.
REQ-032 The bench SHALL check: rst_n asserted in D_WAIT -> immediate IDLE, outputs at reset values; the following mem_rvalid -> err=1, d_rvalid=0.
